// File: rtl/i2c_master_arb2.sv
// i2c_master_arb2
// Two-requester round-robin arbiter in front of a single I2C master.
// A requester asks with rN_req, owns the master while rN_gnt is high and
// talks to the master FIFOs through its own cmd/rxd port; a non-owner sees a
// full command FIFO and an empty receive FIFO.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   rN_req / rN_gnt                  request / registered grant (N = 0,1)
//   rN_cmd_push/_din/_full           requester command FIFO port
//   rN_rxd_pop/_dout/_empty          requester receive FIFO port
//   rN_done                          1-cycle pulse on transaction completion
//   rN_err                           NAK seen during the most recent grant
//   m_cmd_push/_din/_full            master command FIFO
//   m_rxd_pop/_dout/_empty           master receive FIFO
//   m_txd_cmp, m_rxd_cmp             master completion pulses
//   m_addr_nak, m_data_nak           master NAK pulses
module i2c_master_arb2 #(
   parameter int CMD_W = 10,
   parameter int RXD_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             r0_req,
   output logic             r0_gnt,
   input  logic             r0_cmd_push,
   input  logic [CMD_W-1:0] r0_cmd_din,
   output logic             r0_cmd_full,
   input  logic             r0_rxd_pop,
   output logic [RXD_W-1:0] r0_rxd_dout,
   output logic             r0_rxd_empty,
   output logic             r0_done,
   output logic             r0_err,

   input  logic             r1_req,
   output logic             r1_gnt,
   input  logic             r1_cmd_push,
   input  logic [CMD_W-1:0] r1_cmd_din,
   output logic             r1_cmd_full,
   input  logic             r1_rxd_pop,
   output logic [RXD_W-1:0] r1_rxd_dout,
   output logic             r1_rxd_empty,
   output logic             r1_done,
   output logic             r1_err,

   output logic             m_cmd_push,
   output logic [CMD_W-1:0] m_cmd_din,
   input  logic             m_cmd_full,
   output logic             m_rxd_pop,
   input  logic [RXD_W-1:0] m_rxd_dout,
   input  logic             m_rxd_empty,
   input  logic             m_txd_cmp,
   input  logic             m_rxd_cmp,
   input  logic             m_addr_nak,
   input  logic             m_data_nak
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q,  last_d;
   logic [1:0] gnt_q, done_q, err_q;

   logic [1:0] req;
   logic       win;
   logic       cmp;
   logic       nak;

   assign req = {r1_req, r0_req};
   assign cmp = m_txd_cmp | m_rxd_cmp;
   assign nak = m_addr_nak | m_data_nak;

   // On a tie the requester that did not win last time gets the master.
   assign win = r0_req ? (r1_req ? ~last_q : 1'b0) : 1'b1;

   // State register plus the registered grant/done/err flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;

         // Grant follows the next state so it is high exactly in OWN/DONE.
         gnt_q <= '0;
         if (state_d != IDLE) begin
            gnt_q[owner_d] <= 1'b1;
         end

         done_q <= '0;
         if (state_q == OWN && cmp) begin
            done_q[owner_q] <= 1'b1;
         end

         // Clear on grant entry; set only while someone owns the master,
         // so NAKs arriving in IDLE are dropped.
         if (state_q == IDLE && state_d == OWN) begin
            err_q[owner_d] <= 1'b0;
         end else if (state_q != IDLE && nak) begin
            err_q[owner_q] <= 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (r0_req || r1_req) begin
               state_d = OWN;
               owner_d = win;
               last_d  = win;
            end
         end
         OWN: begin
            // Request drop is ignored here: the I2C transfer cannot be aborted.
            if (cmp) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!req[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: route the owner's FIFO ports to the master
   always_comb begin
      logic active;
      active = (state_q != IDLE);

      m_cmd_push   = 1'b0;
      m_cmd_din    = '0;
      m_rxd_pop    = 1'b0;
      r0_cmd_full  = 1'b1;
      r0_rxd_empty = 1'b1;
      r0_rxd_dout  = '0;
      r1_cmd_full  = 1'b1;
      r1_rxd_empty = 1'b1;
      r1_rxd_dout  = '0;

      if (active) begin
         if (owner_q) begin
            m_cmd_push   = r1_cmd_push;
            m_cmd_din    = r1_cmd_din;
            m_rxd_pop    = r1_rxd_pop;
            r1_cmd_full  = m_cmd_full;
            r1_rxd_empty = m_rxd_empty;
            r1_rxd_dout  = m_rxd_dout;
         end else begin
            m_cmd_push   = r0_cmd_push;
            m_cmd_din    = r0_cmd_din;
            m_rxd_pop    = r0_rxd_pop;
            r0_cmd_full  = m_cmd_full;
            r0_rxd_empty = m_rxd_empty;
            r0_rxd_dout  = m_rxd_dout;
         end
      end
   end

   assign r0_gnt  = gnt_q[0];
   assign r1_gnt  = gnt_q[1];
   assign r0_done = done_q[0];
   assign r1_done = done_q[1];
   assign r0_err  = err_q[0];
   assign r1_err  = err_q[1];

endmodule

// File: tb/tb_i2c_master_arb2.sv
// tb_i2c_master_arb2
// Directed self-checking bench for i2c_master_arb2: arbitration order,
// FIFO routing, done/err behaviour and mid-transaction reset.
module tb_i2c_master_arb2;

   localparam int CMD_W = 10;
   localparam int RXD_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             r0_req, r0_gnt, r0_cmd_push, r0_cmd_full, r0_rxd_pop, r0_rxd_empty, r0_done, r0_err;
   logic             r1_req, r1_gnt, r1_cmd_push, r1_cmd_full, r1_rxd_pop, r1_rxd_empty, r1_done, r1_err;
   logic [CMD_W-1:0] r0_cmd_din, r1_cmd_din, m_cmd_din;
   logic [RXD_W-1:0] r0_rxd_dout, r1_rxd_dout, m_rxd_dout;
   logic             m_cmd_push, m_cmd_full, m_rxd_pop, m_rxd_empty;
   logic             m_txd_cmp, m_rxd_cmp, m_addr_nak, m_data_nak;

   int n_vec = 0;
   int n_bad = 0;
   int push_cnt = 0;

   always #5 clk = ~clk;

   i2c_master_arb2 #(.CMD_W(CMD_W), .RXD_W(RXD_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .r0_req       (r0_req),
      .r0_gnt       (r0_gnt),
      .r0_cmd_push  (r0_cmd_push),
      .r0_cmd_din   (r0_cmd_din),
      .r0_cmd_full  (r0_cmd_full),
      .r0_rxd_pop   (r0_rxd_pop),
      .r0_rxd_dout  (r0_rxd_dout),
      .r0_rxd_empty (r0_rxd_empty),
      .r0_done      (r0_done),
      .r0_err       (r0_err),
      .r1_req       (r1_req),
      .r1_gnt       (r1_gnt),
      .r1_cmd_push  (r1_cmd_push),
      .r1_cmd_din   (r1_cmd_din),
      .r1_cmd_full  (r1_cmd_full),
      .r1_rxd_pop   (r1_rxd_pop),
      .r1_rxd_dout  (r1_rxd_dout),
      .r1_rxd_empty (r1_rxd_empty),
      .r1_done      (r1_done),
      .r1_err       (r1_err),
      .m_cmd_push   (m_cmd_push),
      .m_cmd_din    (m_cmd_din),
      .m_cmd_full   (m_cmd_full),
      .m_rxd_pop    (m_rxd_pop),
      .m_rxd_dout   (m_rxd_dout),
      .m_rxd_empty  (m_rxd_empty),
      .m_txd_cmp    (m_txd_cmp),
      .m_rxd_cmp    (m_rxd_cmp),
      .m_addr_nak   (m_addr_nak),
      .m_data_nak   (m_data_nak)
   );

   // Count cycles in which the master command FIFO sees a push.
   always @(negedge clk) begin
      if (m_cmd_push === 1'b1) push_cnt <= push_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      r0_req = 0; r0_cmd_push = 0; r0_cmd_din = '0; r0_rxd_pop = 0;
      r1_req = 0; r1_cmd_push = 0; r1_cmd_din = '0; r1_rxd_pop = 0;
      m_cmd_full = 0; m_rxd_dout = 8'h55; m_rxd_empty = 0;
      m_txd_cmp = 0; m_rxd_cmp = 0; m_addr_nak = 0; m_data_nak = 0;
      step(); step();

      // Reset state; pushes/pops in IDLE must not reach the master
      r0_cmd_push = 1; r0_rxd_pop = 1; #1;
      chk("rst_gnt0", 32'(r0_gnt), 32'd0);
      chk("rst_gnt1", 32'(r1_gnt), 32'd0);
      chk("rst_done", 32'({r1_done, r0_done}), 32'd0);
      chk("rst_err", 32'({r1_err, r0_err}), 32'd0);
      chk("idle_mpush", 32'(m_cmd_push), 32'd0);
      chk("idle_mpop", 32'(m_rxd_pop), 32'd0);
      chk("idle_full0", 32'(r0_cmd_full), 32'd1);
      chk("idle_empty0", 32'(r0_rxd_empty), 32'd1);
      chk("idle_dout0", 32'(r0_rxd_dout), 32'd0);
      r0_cmd_push = 0; r0_rxd_pop = 0;

      // Simultaneous requests after reset: r0 wins
      rst_n = 1; r0_req = 1; r1_req = 1;
      step();
      chk("tie_gnt0", 32'(r0_gnt), 32'd1);
      chk("tie_gnt1", 32'(r1_gnt), 32'd0);

      // Receive routing to owner only
      m_rxd_empty = 0; m_rxd_dout = 8'hA0; #1;
      chk("own_empty0", 32'(r0_rxd_empty), 32'd0);
      chk("own_dout0", 32'(r0_rxd_dout), 32'hA0);
      chk("nown_empty1", 32'(r1_rxd_empty), 32'd1);
      chk("nown_dout1", 32'(r1_rxd_dout), 32'd0);

      // Read completion: done one cycle after the cmp pulse
      m_rxd_cmp = 1;
      step();
      m_rxd_cmp = 0;
      chk("rd_done0", 32'(r0_done), 32'd1);
      chk("rd_done1", 32'(r1_done), 32'd0);
      chk("rd_gnt0", 32'(r0_gnt), 32'd1);
      step();
      chk("rd_done0_off", 32'(r0_done), 32'd0);

      // Drain 4 bytes while in DONE
      for (int i = 0; i < 4; i++) begin
         m_rxd_dout = 8'hA1 + 8'(i); r0_rxd_pop = 1; r1_rxd_pop = 1; #1;
         chk("drain_dout0", 32'(r0_rxd_dout), 32'hA1 + 32'(i));
         chk("drain_mpop", 32'(m_rxd_pop), 32'd1);
         chk("drain_empty1", 32'(r1_rxd_empty), 32'd1);
         step();
      end
      r0_rxd_pop = 0; #1;
      chk("nown_pop_drop", 32'(m_rxd_pop), 32'd0);
      r1_rxd_pop = 0;

      // r0 releases; one IDLE cycle then r1
      r0_req = 0;
      step();
      chk("gap_gnt0", 32'(r0_gnt), 32'd0);
      chk("gap_gnt1", 32'(r1_gnt), 32'd0);
      step();
      chk("rr_gnt1", 32'(r1_gnt), 32'd1);
      chk("rr_gnt0", 32'(r0_gnt), 32'd0);

      // r1 pushes 8 commands; r0 pushes dropped
      base = push_cnt;
      m_cmd_full = 0;
      for (int i = 0; i < 8; i++) begin
         r1_cmd_push = 1; r1_cmd_din = 10'h300 + 10'(i * 7);
         r0_cmd_push = 1; r0_cmd_din = 10'h0AA;
         #1;
         chk("push_m", 32'(m_cmd_push), 32'd1);
         chk("push_din", 32'(m_cmd_din), 32'h300 + 32'(i * 7));
         chk("push_full0", 32'(r0_cmd_full), 32'd1);
         step();
      end
      r1_cmd_push = 0; r0_cmd_push = 0;
      m_cmd_full = 1; #1;
      chk("full_pass1", 32'(r1_cmd_full), 32'd1);
      chk("push_none", 32'(m_cmd_push), 32'd0);
      m_cmd_full = 0;
      step(); step();
      chk("push_count", 32'(push_cnt - base), 32'd8);

      // Simultaneous cmp and NAK: done and err both
      m_txd_cmp = 1; m_data_nak = 1;
      step();
      m_txd_cmp = 0; m_data_nak = 0;
      chk("both_done1", 32'(r1_done), 32'd1);
      chk("both_err1", 32'(r1_err), 32'd1);
      chk("both_err0", 32'(r0_err), 32'd0);
      r1_req = 0;
      step();
      chk("rel_gnt1", 32'(r1_gnt), 32'd0);
      chk("hold_err1", 32'(r1_err), 32'd1);

      // r0 grant with address NAK
      r0_req = 1;
      step();
      chk("g0_gnt", 32'(r0_gnt), 32'd1);
      chk("g0_err_clr", 32'(r0_err), 32'd0);
      m_addr_nak = 1;
      step();
      m_addr_nak = 0;
      chk("nak_err0", 32'(r0_err), 32'd1);
      chk("nak_nodone", 32'(r0_done), 32'd0);

      // Early release: grant held until cmp
      r0_req = 0;
      step(); step(); step();
      chk("hold_gnt0", 32'(r0_gnt), 32'd1);
      m_txd_cmp = 1;
      step();
      m_txd_cmp = 0;
      chk("late_done0", 32'(r0_done), 32'd1);
      chk("late_gnt0", 32'(r0_gnt), 32'd1);
      step();
      chk("late_idle", 32'(r0_gnt), 32'd0);
      chk("idle_err0", 32'(r0_err), 32'd1);

      // Stray cmp/NAK in IDLE ignored
      m_txd_cmp = 1; m_data_nak = 1;
      step();
      m_txd_cmp = 0; m_data_nak = 0;
      chk("stray_done", 32'({r1_done, r0_done}), 32'd0);
      chk("stray_gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
      chk("stray_err", 32'({r1_err, r0_err}), 32'd3);

      // Next r0 grant clears err
      r0_req = 1;
      step();
      chk("g0b_gnt", 32'(r0_gnt), 32'd1);
      chk("g0b_err", 32'(r0_err), 32'd0);
      m_txd_cmp = 1;
      step();
      m_txd_cmp = 0;
      r0_req = 0; r1_req = 1;
      step();
      chk("g0b_idle", 32'({r1_gnt, r0_gnt}), 32'd0);

      // Tie with last winner r0: r1 wins
      r0_req = 1;
      step();
      chk("tie2_gnt", 32'({r1_gnt, r0_gnt}), 32'd2);
      chk("tie2_err1", 32'(r1_err), 32'd0);

      // Reset mid-transaction
      r1_cmd_push = 1; r1_cmd_din = 10'h155; #1;
      chk("pre_rst_push", 32'(m_cmd_push), 32'd1);
      rst_n = 0;
      step();
      chk("mid_rst_gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
      chk("mid_rst_push", 32'(m_cmd_push), 32'd0);
      chk("mid_rst_full1", 32'(r1_cmd_full), 32'd1);
      r1_cmd_push = 0;
      rst_n = 1;
      step();
      chk("post_rst_gnt", 32'({r1_gnt, r0_gnt}), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
